// File: rtl/dot_product_row_feeder.sv
// dot_product_row_feeder: sequences matrix/vector packages into an 8-lane dot-product unit and writes one result per row
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, n_rows, row_len     job request; n_rows/row_len sampled when start is accepted in IDLE
//   mat_addr/mat_rdata         matrix package memory, data valid one cycle after address
//   vec_addr/vec_rdata         vector package memory, data valid one cycle after address
//   dp_first_row/second_row    registered packages to the dot-product unit, strobed by dp_read_now
//   dp_total, dp_reset         row length and per-row clear for the dot-product unit
//   dp_finish, dp_result       dot-product completion level and scalar result
//   res_we/res_addr/res_data   result write port, one write per row at address = row
//   busy, done, err            status; done is a one-cycle pulse, err holds until the next valid start
// Option macro FEEDER_PERF_CNT_EN adds stall_cycles (cycles spent waiting on dp_finish)
//   and pkt_count (packages presented), both cleared on start and saturating.
module dot_product_row_feeder #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int NO_OF_UNITS   = 8,
    parameter int ADDR_W        = 10,
    parameter int PKG_HOLD      = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [ADDR_W-1:0]                      n_rows,
    input  logic [31:0]                            row_len,
    output logic [ADDR_W-1:0]                      mat_addr,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]   mat_rdata,
    output logic [ADDR_W-1:0]                      vec_addr,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]   vec_rdata,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]   dp_first_row,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]   dp_second_row,
    output logic                                   dp_read_now,
    output logic [31:0]                            dp_total,
    output logic                                   dp_reset,
    input  logic                                   dp_finish,
    input  logic [ELEMENT_WIDTH-1:0]               dp_result,
    output logic                                   res_we,
    output logic [ADDR_W-1:0]                      res_addr,
    output logic [ELEMENT_WIDTH-1:0]               res_data,
    output logic                                   busy,
    output logic                                   done,
`ifdef FEEDER_PERF_CNT_EN
    output logic [31:0]                            stall_cycles,
    output logic [31:0]                            pkt_count,
`endif
    output logic                                   err
);
    localparam int PW = ELEMENT_WIDTH * NO_OF_UNITS;

    typedef enum logic [2:0] {IDLE, CLR, FETCH, LOAD, PRESENT, WAIT_DP, WRITE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      rows_q, rows_d, row_q, row_d;
    logic [31:0]            pkgs_q, pkgs_d, pkg_q, pkg_d, total_q, total_d, hold_q, hold_d;
    logic [PW-1:0]          first_q, first_d, second_q, second_d;
    logic [ELEMENT_WIDTH-1:0] res_q, res_d;
    logic                   err_q, err_d;
    logic                   bad;

    // A job with no rows or a row that does not split into whole packages is rejected outright
    assign bad = n_rows == '0 || row_len == '0 || row_len % 32'(NO_OF_UNITS) != '0;

    always_comb begin
        state_d  = state_q;
        rows_d   = rows_q;
        row_d    = row_q;
        pkgs_d   = pkgs_q;
        pkg_d    = pkg_q;
        total_d  = total_q;
        hold_d   = hold_q;
        first_d  = first_q;
        second_d = second_q;
        res_d    = res_q;
        err_d    = err_q;
        case (state_q)
            IDLE: if (start) begin
                rows_d  = n_rows;
                total_d = row_len;
                pkgs_d  = row_len / 32'(NO_OF_UNITS);
                row_d   = '0;
                pkg_d   = '0;
                err_d   = bad;
                state_d = bad ? DONE : CLR;
            end
            CLR:   state_d = FETCH;
            FETCH: state_d = LOAD;
            LOAD: begin
                first_d  = mat_rdata;
                second_d = vec_rdata;
                hold_d   = '0;
                state_d  = PRESENT;
            end
            PRESENT: begin
                hold_d = hold_q + 1;
                if (hold_q == 32'(PKG_HOLD - 1)) begin
                    pkg_d   = pkg_q + 1;
                    state_d = pkg_q + 1 == pkgs_q ? WAIT_DP : FETCH;
                end
            end
            WAIT_DP: if (dp_finish) begin
                res_d   = dp_result;
                state_d = WRITE;
            end
            WRITE: begin
                if (32'(row_q) + 1 < 32'(rows_q)) begin
                    row_d   = row_q + 1'b1;
                    pkg_d   = '0;
                    state_d = CLR;
                end else
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rows_q   <= '0;
            row_q    <= '0;
            pkgs_q   <= '0;
            pkg_q    <= '0;
            total_q  <= '0;
            hold_q   <= '0;
            first_q  <= '0;
            second_q <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rows_q   <= rows_d;
            row_q    <= row_d;
            pkgs_q   <= pkgs_d;
            pkg_q    <= pkg_d;
            total_q  <= total_d;
            hold_q   <= hold_d;
            first_q  <= first_d;
            second_q <= second_d;
            res_q    <= res_d;
            err_q    <= err_d;
        end
    end

    // Addresses are only driven during FETCH so the memories see a quiet bus otherwise
    assign mat_addr      = state_q == FETCH ? ADDR_W'(32'(row_q) * pkgs_q + pkg_q) : '0;
    assign vec_addr      = state_q == FETCH ? ADDR_W'(pkg_q) : '0;
    assign dp_first_row  = first_q;
    assign dp_second_row = second_q;
    assign dp_read_now   = state_q == PRESENT;
    assign dp_total      = total_q;
    assign dp_reset      = state_q == CLR;
    assign res_we        = state_q == WRITE;
    assign res_addr      = state_q == WRITE ? row_q : '0;
    assign res_data      = res_q;
    assign busy          = state_q != IDLE;
    assign done          = state_q == DONE;
    assign err           = err_q;

`ifdef FEEDER_PERF_CNT_EN
    logic [31:0] stall_q, pkt_q;

    always_ff @(posedge clk) begin
        if (reset || (start && state_q == IDLE)) begin
            stall_q <= '0;
            pkt_q   <= '0;
        end else begin
            if (state_q == WAIT_DP && stall_q != '1)
                stall_q <= stall_q + 1;
            if (state_q == PRESENT && hold_q == '0 && pkt_q != '1)
                pkt_q <= pkt_q + 1;
        end
    end

    assign stall_cycles = stall_q;
    assign pkt_count    = pkt_q;
`endif
endmodule

// File: tb/tb_dot_product_row_feeder.sv
// tb_dot_product_row_feeder: randomized scoreboard bench with memory and dot-product unit models
module tb_dot_product_row_feeder;
    localparam int EW = 32, NU = 8, AW = 10, PH = 2, PW = EW * NU;

    logic clk = 0, reset = 1, start = 0;
    logic [AW-1:0] n_rows = '0;
    logic [31:0] row_len = '0;
    logic [AW-1:0] mat_addr, vec_addr, res_addr;
    logic [PW-1:0] mat_rdata, vec_rdata, dp_first_row, dp_second_row;
    logic dp_read_now, dp_reset, res_we, busy, done, err;
    logic [31:0] dp_total;
    logic dp_finish;
    logic [EW-1:0] dp_result, res_data;
`ifdef FEEDER_PERF_CNT_EN
    logic [31:0] stall_cycles, pkt_count;
`endif

    dot_product_row_feeder #(.ELEMENT_WIDTH(EW), .NO_OF_UNITS(NU), .ADDR_W(AW), .PKG_HOLD(PH)) dut (
        .clk(clk), .reset(reset), .start(start), .n_rows(n_rows), .row_len(row_len),
        .mat_addr(mat_addr), .mat_rdata(mat_rdata), .vec_addr(vec_addr), .vec_rdata(vec_rdata),
        .dp_first_row(dp_first_row), .dp_second_row(dp_second_row), .dp_read_now(dp_read_now),
        .dp_total(dp_total), .dp_reset(dp_reset), .dp_finish(dp_finish), .dp_result(dp_result),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data), .busy(busy), .done(done),
`ifdef FEEDER_PERF_CNT_EN
        .stall_cycles(stall_cycles), .pkt_count(pkt_count),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    logic [63:0] exp_q[$];
    logic [PW-1:0] mat_mem [0:(1<<AW)-1];
    logic [PW-1:0] vec_mem [0:(1<<AW)-1];
    int cur_pkgs = 0, cur_delay = 0;
    bit override = 0;
    logic [31:0] exp_total = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dot8(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [31:0] s = '0;
        for (int l = 0; l < NU; l++) s += a[l*EW +: EW] * b[l*EW +: EW];
        return s;
    endfunction

    always @(posedge clk) begin
        mat_rdata <= mat_mem[mat_addr];
        vec_rdata <= vec_mem[vec_addr];
    end

    // Dot-product unit model: accumulates each package once, raises dp_finish after cur_delay idle cycles
    logic [31:0] acc;
    int nb, wc;
    bit dpm_prev;
    always @(negedge clk) begin
        if (reset || dp_reset) begin
            acc = '0; nb = 0; wc = 0; dp_finish = 0; dp_result = '0;
        end else begin
            if (dp_read_now && !dpm_prev) begin
                acc += dot8(dp_first_row, dp_second_row);
                nb++;
            end
            if (nb == cur_pkgs && !dp_read_now && !dp_finish) begin
                if (wc == cur_delay) begin
                    dp_finish = 1;
                    dp_result = override ? 32'h41800000 : acc;
                end else
                    wc++;
            end
        end
        dpm_prev = reset ? 1'b0 : dp_read_now;
    end

    // Monitor: burst shape, package stability, result writes against the scoreboard
    int rn_len = 0, job_bursts = 0, job_clr = 0, job_done = 0;
    bit prev_rn = 0;
    logic [PW-1:0] hold_row, hold_vec;
    logic [63:0] e;
    always @(negedge clk) begin
        if (reset) begin
            rn_len = 0; prev_rn = 0;
        end else begin
            if (start && !busy) begin job_bursts = 0; job_clr = 0; job_done = 0; end
            if (dp_reset) job_clr++;
            if (dp_read_now) begin
                if (!prev_rn) begin
                    hold_row = dp_first_row; hold_vec = dp_second_row; job_bursts++;
                end else
                    chk("pkg_stable", 64'(dp_first_row == hold_row && dp_second_row == hold_vec), 1);
                rn_len++;
            end else if (prev_rn) begin
                chk("burst_len", rn_len, PH);
                rn_len = 0;
            end
            prev_rn = dp_read_now;
            if (busy) chk("dp_total", dp_total, exp_total);
            if (res_we) begin
                if (exp_q.size() == 0) chk("unexpected_write", {32'(res_addr), res_data}, 64'hffff_ffff_ffff_ffff);
                else begin
                    e = exp_q.pop_front();
                    chk("res_addr", res_addr, e[63:32]);
                    chk("res_data", res_data, e[31:0]);
                end
            end
            if (done) job_done++;
        end
    end

    task automatic fill_expect(input int nr, input int pk);
        logic [31:0] s;
        for (int p = 0; p < pk; p++)
            for (int l = 0; l < NU; l++) vec_mem[p][l*EW +: EW] = $urandom;
        for (int a = 0; a < nr * pk; a++)
            for (int l = 0; l < NU; l++) mat_mem[a][l*EW +: EW] = $urandom;
        for (int r = 0; r < nr; r++) begin
            s = '0;
            for (int p = 0; p < pk; p++) s += dot8(mat_mem[r*pk + p], vec_mem[p]);
            exp_q.push_back({32'(r), s});
        end
    endtask

    task automatic pulse_start(input int nr, input int rl);
        @(posedge clk); #1;
        n_rows = AW'(nr); row_len = 32'(rl); start = 1;
        @(posedge clk); #1;
        start = 0; n_rows = AW'($urandom); row_len = $urandom;
    endtask

    task automatic run_job(input int nr, input int rl, input int dly, input bit ovr, input bit restart, input bit prefilled);
        bit bad = nr == 0 || rl == 0 || rl % NU != 0;
        int pk = rl / NU;
        int cyc = 0;
        if (!bad && !prefilled) fill_expect(nr, pk);
        cur_pkgs = pk; cur_delay = dly; override = ovr; exp_total = 32'(rl);
        pulse_start(nr, rl);
        while (!done && cyc < 2000) begin
            if (restart) begin
                start = cyc == 20;
                n_rows = 5; row_len = 8;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 0;
        chk("done_seen", 64'(done), 1);
        if (bad) chk("err_done_latency", 64'(cyc <= 1), 1);
        chk("err_flag", 64'(err), 64'(bad));
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 0);
        chk("err_hold", 64'(err), 64'(bad));
        chk("done_count", job_done, 1);
        chk("bursts", job_bursts, bad ? 0 : nr * pk);
        chk("dp_reset_count", job_clr, bad ? 0 : nr);
        chk("writes_left", exp_q.size(), 0);
`ifdef FEEDER_PERF_CNT_EN
        chk("pkt_count", pkt_count, bad ? 0 : nr * pk);
        chk("stall_cycles", stall_cycles, bad ? 0 : nr * (dly + 1));
`endif
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {51'd0, |mat_addr, |vec_addr, |dp_first_row, |dp_second_row, dp_read_now, |dp_total,
                 dp_reset, res_we, |res_addr, |res_data, busy, done, err}, 0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_state");
        reset = 0;

        for (int l = 0; l < NU; l++) begin
            mat_mem[0][l*EW +: EW] = 32'h3f800000;
            vec_mem[0][l*EW +: EW] = 32'h40000000;
        end
        exp_q.push_back({32'd0, 32'h41800000});
        run_job(1, 8, 2, 1, 0, 1);

        run_job(3, 16, 1, 0, 0, 0);
        run_job(1, 12, 0, 0, 0, 0);
        run_job(0, 16, 0, 0, 0, 0);
        run_job(2, 0, 0, 0, 0, 0);
        run_job(1, 16, 49, 0, 0, 0);

        fill_expect(3, 2);
        cur_pkgs = 2; cur_delay = 3; override = 0; exp_total = 16;
        pulse_start(3, 16);
        cyc = 0;
        while (!(job_clr == 2 && dp_read_now) && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reach_row1_present", 64'(cyc < 500), 1);
        reset = 1;
        @(posedge clk); #1;
        chk_zero("mid_job_reset");
        exp_q.delete();
        reset = 0;
        run_job(3, 16, 2, 0, 0, 0);

        run_job(2, 8, 40, 0, 1, 0);

        for (int k = 0; k < 8; k++)
            run_job($urandom_range(1, 4), NU * $urandom_range(1, 4), $urandom_range(0, 6), 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
